// File: rtl/mesh_walker.sv
// Mesh walker: fetches the four corner vertices of each grid cell and hands two triangles per cell to the triangle unit.
// Optional build macro MESH_WALKER_CULL_EN drops triangles whose three y values are equal.
module mesh_walker (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [5:0]  hlast,
  input  logic [5:0]  vlast,
  output logic [11:0] vaddr,
  input  logic [43:0] vdata,
  output logic [10:0] xa,
  output logic [10:0] ya,
  output logic [10:0] ua,
  output logic [10:0] va,
  output logic [10:0] xb,
  output logic [10:0] yb,
  output logic [10:0] ub,
  output logic [10:0] vb,
  output logic [10:0] xc,
  output logic [10:0] yc,
  output logic [10:0] uc,
  output logic [10:0] vc,
  output logic        load,
  input  logic        tri_ready,
  output logic        busy,
  output logic        done
);

  typedef enum logic [3:0] {
    S_IDLE, S_F0, S_F1, S_F2, S_F3, S_F4,
    S_WAIT1, S_LOAD1, S_GAP1, S_WAIT2, S_LOAD2, S_GAP2,
    S_ADVANCE, S_FINISH
  } state_t;

  state_t      r_state, w_next;
  logic [5:0]  r_hl, r_vl, r_row, r_col;
  logic [5:0]  w_nrow, w_ncol;
  logic [11:0] r_vaddr;
  logic [43:0] r_p00, r_p01, r_p10, r_p11;
  logic [43:0] r_a, r_b, r_c;
  logic        r_done;
  logic        w_empty, w_last_col, w_last_row, w_last_cell;
  logic        w_cull1, w_cull2;

  assign w_empty     = (hlast == 6'd0) || (vlast == 6'd0);
  assign w_last_col  = (r_col == r_hl - 6'd1);
  assign w_last_row  = (r_row == r_vl - 6'd1);
  assign w_last_cell = w_last_col && w_last_row;
  assign w_ncol      = w_last_col ? 6'd0 : r_col + 6'd1;
  assign w_nrow      = w_last_col ? r_row + 6'd1 : r_row;

`ifdef MESH_WALKER_CULL_EN
  // y lives in bits [32:22] of a vertex word
  assign w_cull1 = (r_p00[32:22] == r_p01[32:22]) && (r_p01[32:22] == r_p10[32:22]);
  assign w_cull2 = (r_p01[32:22] == r_p11[32:22]) && (r_p11[32:22] == r_p10[32:22]);
`else
  assign w_cull1 = 1'b0;
  assign w_cull2 = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (start && !w_empty) w_next = S_F0;
      S_F0:      w_next = S_F1;
      S_F1:      w_next = S_F2;
      S_F2:      w_next = S_F3;
      S_F3:      w_next = S_F4;
      S_F4:      w_next = S_WAIT1;
      S_WAIT1:   if (w_cull1) w_next = S_WAIT2;
                 else if (tri_ready) w_next = S_LOAD1;
      S_LOAD1:   w_next = S_GAP1;
      S_GAP1:    w_next = S_WAIT2;
      S_WAIT2:   if (w_cull2) w_next = S_ADVANCE;
                 else if (tri_ready) w_next = S_LOAD2;
      S_LOAD2:   w_next = S_GAP2;
      S_GAP2:    w_next = S_ADVANCE;
      S_ADVANCE: w_next = w_last_cell ? S_FINISH : S_F0;
      S_FINISH:  if (tri_ready) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // vaddr is registered one state ahead so it is presented during F0..F3 itself
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hl    <= '0;
      r_vl    <= '0;
      r_row   <= '0;
      r_col   <= '0;
      r_vaddr <= '0;
      r_p00   <= '0;
      r_p01   <= '0;
      r_p10   <= '0;
      r_p11   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (start) begin
          r_hl  <= hlast;
          r_vl  <= vlast;
          r_row <= '0;
          r_col <= '0;
          if (w_empty) r_done  <= 1'b1;
          else         r_vaddr <= 12'd0;
        end
        S_F0: r_vaddr <= {r_row, r_col + 6'd1};
        S_F1: begin
          r_vaddr <= {r_row + 6'd1, r_col};
          r_p00   <= vdata;
        end
        S_F2: begin
          r_vaddr <= {r_row + 6'd1, r_col + 6'd1};
          r_p01   <= vdata;
        end
        S_F3: r_p10 <= vdata;
        S_F4: r_p11 <= vdata;
        S_WAIT1: if (!w_cull1 && tri_ready) begin
          r_a <= r_p00;
          r_b <= r_p01;
          r_c <= r_p10;
        end
        S_WAIT2: if (!w_cull2 && tri_ready) begin
          r_a <= r_p01;
          r_b <= r_p11;
          r_c <= r_p10;
        end
        S_ADVANCE: if (!w_last_cell) begin
          r_row   <= w_nrow;
          r_col   <= w_ncol;
          r_vaddr <= {w_nrow, w_ncol};
        end
        S_FINISH: if (tri_ready) r_done <= 1'b1;
        default: ;
      endcase
    end
  end

  assign vaddr = r_vaddr;
  assign {xa, ya, ua, va} = r_a;
  assign {xb, yb, ub, vb} = r_b;
  assign {xc, yc, uc, vc} = r_c;
  assign load = (r_state == S_LOAD1) || (r_state == S_LOAD2);
  assign busy = (r_state != S_IDLE);
  assign done = r_done;

endmodule

// File: tb/tb_mesh_walker.sv
// Bench for mesh_walker: vertex memory, triangle-unit responder and a cell-list reference model.
`timescale 1ns/1ps
module tb_mesh_walker;
  logic        clk = 1'b0;
  logic        rst, start;
  logic [5:0]  hlast, vlast;
  logic [11:0] vaddr;
  logic [43:0] vdata;
  logic [10:0] xa, ya, ua, va, xb, yb, ub, vb, xc, yc, uc, vc;
  logic        load, busy, done;
  logic        tri_ready = 1'b1;

  mesh_walker dut (
    .clk(clk), .rst(rst), .start(start), .hlast(hlast), .vlast(vlast),
    .vaddr(vaddr), .vdata(vdata),
    .xa(xa), .ya(ya), .ua(ua), .va(va), .xb(xb), .yb(yb), .ub(ub), .vb(vb),
    .xc(xc), .yc(yc), .uc(uc), .vc(vc),
    .load(load), .tri_ready(tri_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [43:0]  mem [0:4095];
  always @(posedge clk) vdata <= mem[vaddr];

  logic [131:0] w_tri;
  assign w_tri = {xa, ya, ua, va, xb, yb, ub, vb, xc, yc, uc, vc};

  // triangle-unit responder and observer
  int           cyc = 0, cnt = 0, stall_left = 0;
  int           lat, n_done = 0, n_bad_rdy = 0, n_bad_stable = 0;
  bit           stall_mode, stall_armed = 0, have_last = 0;
  logic [131:0] last;
  logic [131:0] tq[$];
  int           lcyc[$];
  logic [11:0]  alog[$];

  always @(negedge clk) begin
    cyc++;
    if (rst) have_last = 0;
    else if (load) begin
      if (!tri_ready) n_bad_rdy++;
      tq.push_back(w_tri);
      lcyc.push_back(cyc);
      last = w_tri;
      have_last = 1;
      cnt = lat;
      if (stall_mode && !stall_armed) begin
        stall_armed = 1;
        stall_left = 20;
      end
    end else begin
      if (have_last && w_tri !== last) n_bad_stable++;
      if (cnt > 0) cnt--;
      if (stall_left > 0) stall_left--;
    end
    if (!stall_mode) stall_armed = 0;
    if (done) n_done++;
    if (busy && (alog.size() == 0 || alog[$] !== vaddr)) alog.push_back(vaddr);
    tri_ready = (cnt == 0) && (stall_left == 0);
  end

  int           n_chk = 0, n_pass = 0;
  logic [131:0] eq[$];

  task automatic chk(input string tag, input logic [131:0] obs, input logic [131:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [43:0] vw(input int x, input int y, input int u, input int v);
    return {x[10:0], y[10:0], u[10:0], v[10:0]};
  endfunction

  function automatic logic [43:0] vtx(input int r, input int c);
    return mem[{r[5:0], c[5:0]}];
  endfunction

  function automatic bit flat(input logic [43:0] a, input logic [43:0] b, input logic [43:0] c);
`ifdef MESH_WALKER_CULL_EN
    return (a[32:22] == b[32:22]) && (b[32:22] == c[32:22]);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [131:0] tqat(input int i);
    return (i < tq.size()) ? tq[i] : 132'd0;
  endfunction

  function automatic logic [11:0] aat(input int i);
    return (i < alog.size()) ? alog[i] : 12'hfff;
  endfunction

  // expected triangle stream: two triangles per cell, raster order
  task automatic build_exp(input int hl, input int vl);
    logic [43:0] p00, p01, p10, p11;
    eq.delete();
    for (int i = 0; i < vl; i++)
      for (int j = 0; j < hl; j++) begin
        p00 = vtx(i, j);     p01 = vtx(i, j + 1);
        p10 = vtx(i + 1, j); p11 = vtx(i + 1, j + 1);
        if (!flat(p00, p01, p10)) eq.push_back({p00, p01, p10});
        if (!flat(p01, p11, p10)) eq.push_back({p01, p11, p10});
      end
  endtask

  task automatic fill_random();
    logic [63:0] w;
    for (int a = 0; a < 512; a++) begin
      w = {$urandom, $urandom};
      mem[a] = w[43:0];
    end
  endtask

  task automatic run_walk(input string nm, input int hl, input int vl, input int latency, input bit disturb);
    int t, b_t, b_d, m;
    build_exp(hl, vl);
    lat = latency;
    b_t = tq.size();
    b_d = n_done;
    @(negedge clk); hlast = hl[5:0]; vlast = vl[5:0]; start = 1'b1;
    @(negedge clk); start = 1'b0;
    if (disturb) begin
      hlast = 6'd5; vlast = 6'd4;
      repeat (3) @(negedge clk);
      start = 1'b1;
      @(negedge clk); start = 1'b0;
    end
    t = 0;
    while (n_done == b_d && t < 5000) begin @(negedge clk); t++; end
    chk({nm, "_timeout"}, t < 5000, 1);
    chk({nm, "_idle"}, busy, 0);
    repeat (3) @(negedge clk);
    chk({nm, "_done_cnt"}, n_done - b_d, 1);
    chk({nm, "_nloads"}, tq.size() - b_t, eq.size());
    m = (tq.size() - b_t < eq.size()) ? tq.size() - b_t : eq.size();
    for (int k = 0; k < m; k++) chk({nm, "_tri"}, tqat(b_t + k), eq[k]);
    chk({nm, "_load_rdy"}, n_bad_rdy, 0);
    chk({nm, "_stable"}, n_bad_stable, 0);
  endtask

  initial begin
    int b, t;
    rst = 1'b1; start = 1'b0; hlast = '0; vlast = '0; lat = 0; stall_mode = 0;
    for (int a = 0; a < 4096; a++) mem[a] = '0;
    repeat (3) @(negedge clk);
    chk("rst_load", load, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_vaddr", vaddr, 0);
    chk("rst_tri", w_tri, 0);
    rst = 1'b0;

    // single cell, x=10c y=10r
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) mem[{r[5:0], c[5:0]}] = vw(10 * c, 10 * r, c, r);
    b = tq.size();
    run_walk("basic", 1, 1, 0, 0);
    chk("basic_t1", tqat(b), {vw(0, 0, 0, 0), vw(10, 0, 1, 0), vw(0, 10, 0, 1)});
    chk("basic_t2", tqat(b + 1), {vw(10, 0, 1, 0), vw(10, 10, 1, 1), vw(0, 10, 0, 1)});

    // 3x2 grid; inputs changed and start re-pulsed mid-walk
    fill_random();
    b = alog.size();
    run_walk("grid", 3, 2, 1, 1);
    chk("grid_naddr", alog.size() - b, 24);
    chk("grid_c1a0", aat(b + 4), 12'h001);
    chk("grid_c1a1", aat(b + 5), 12'h002);
    chk("grid_c1a2", aat(b + 6), 12'h041);
    chk("grid_c1a3", aat(b + 7), 12'h042);

    // tri_ready held low 20 cycles after the first load
    fill_random();
    stall_mode = 1;
    b = lcyc.size();
    run_walk("stall", 2, 1, 0, 0);
    stall_mode = 0;
    chk("stall_gap", (lcyc.size() > b + 1) && (lcyc[b + 1] - lcyc[b] >= 21), 1);

    // empty mesh
    b = tq.size();
    @(negedge clk); hlast = 6'd0; vlast = 6'd5; start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("empty_done", done, 1);
    chk("empty_busy", busy, 0);
    @(negedge clk);
    chk("empty_done_pulse", done, 0);
    repeat (8) @(negedge clk);
    chk("empty_loads", tq.size() - b, 0);

    // reset while waiting for the second triangle of cell 0
    fill_random();
    b = tq.size();
    lat = 8;
    @(negedge clk); hlast = 6'd2; vlast = 6'd2; start = 1'b1;
    @(negedge clk); start = 1'b0;
    t = 0;
    while (tq.size() == b && t < 500) begin @(negedge clk); t++; end
    chk("abort_first_load", t < 500, 1);
    repeat (3) @(negedge clk);
    chk("abort_pre_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_load", load, 0);
    chk("abort_busy", busy, 0);
    @(negedge clk); rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("abort_noload", tq.size() - b, 1);
    run_walk("restart", 2, 2, 2, 0);

    // flat rows 0 and 1 (y=0); row 2 raised
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        mem[{r[5:0], c[5:0]}] = vw($urandom_range(0, 2047), (r == 2) ? 300 + c : 0,
                                    $urandom_range(0, 2047), $urandom_range(0, 2047));
    b = tq.size();
    run_walk("flat", 2, 2, 1, 0);
`ifdef MESH_WALKER_CULL_EN
    chk("flat_count", tq.size() - b, 4);
`else
    chk("flat_count", tq.size() - b, 8);
`endif

    for (int k = 0; k < 3; k++) begin
      fill_random();
      run_walk("rnd", $urandom_range(1, 4), $urandom_range(1, 3), $urandom_range(0, 3), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mesh_walker.md
MESH_WALKER -- requirements
Module: mesh_walker

Interface
REQ-001 SHALL have port clk  in  1  system clock; all logic on rising edge.
REQ-002 SHALL have port rst  in  1  reset; one clock; reset is synchronous and active-high.
REQ-003 SHALL have port start  in  1  one-cycle pulse; begin walking the mesh.
REQ-004 SHALL have port hlast  in  6  index of last vertex column (cells per row = hlast).
REQ-005 SHALL have port vlast  in  6  index of last vertex row (cell rows = vlast).
REQ-006 SHALL have port vaddr  out  12  vertex memory address {row[5:0], col[5:0]}.
REQ-007 SHALL have port vdata  in  44  vertex word {x[43:33], y[32:22], u[21:11], v[10:0]}, valid one cycle after vaddr.
REQ-008 SHALL have ports xa,ya,ua,va,xb,yb,ub,vb,xc,yc,uc,vc  out  11 each  triangle vertices to the triangle unit.
REQ-009 SHALL have port load  out  1  one-cycle pulse; triangle outputs valid.
REQ-010 SHALL have port tri_ready  in  1  triangle unit idle and able to accept load.
REQ-011 SHALL have port busy  out  1  walk in progress.
REQ-012 SHALL have port done  out  1  one-cycle pulse; walk complete.

Function
REQ-013 SHALL latch hlast/vlast on accepted start; later input changes SHALL NOT affect the walk.
REQ-014 SHALL accept start only in IDLE; start while busy SHALL be ignored.
REQ-015 SHALL visit cells (i=row, j=col) in raster order: j 0..hlast-1 inner, i 0..vlast-1 outer.
REQ-016 SHALL per cell issue vaddr for P00=(i,j), P01=(i,j+1), P10=(i+1,j), P11=(i+1,j+1) in 4 consecutive cycles (F0..F3), capturing vdata in F1..F4.
REQ-017 SHALL emit triangle T1 as A=P00, B=P01, C=P10, then T2 as A=P01, B=P11, C=P10.
REQ-018 SHALL hold x*/y*/u*/v* stable from the cycle load is asserted until the next load.
REQ-019 SHALL assert load only in a cycle where tri_ready=1, and only after the fetch for that cell is complete.
REQ-020 SHALL, after each load, ignore tri_ready for exactly one cycle (GAP) before sampling it again.
REQ-021 SHALL use states IDLE -> F0..F4 -> WAIT1 -> LOAD1 -> GAP1 -> WAIT2 -> LOAD2 -> GAP2 -> ADVANCE -> (F0 | FINISH) -> IDLE.
REQ-022 SHALL leave FINISH, pulse done, and enter IDLE on the first cycle tri_ready=1 after the final load.
REQ-023 SHALL, if hlast=0 or vlast=0 at start, issue no fetch or load and pulse done the cycle after start.
REQ-024 SHALL assert busy in every state except IDLE.
REQ-025 SHALL hold vaddr at its last value outside F0..F3; vertex values pass unmodified (no arithmetic on coordinates).

Reset
REQ-026 SHALL on rst=1 enter IDLE and force load=0, done=0, busy=0, vaddr=0, all triangle outputs=0, cell counters=0.
REQ-027 SHALL abort any walk when rst is asserted mid-operation; no further load until a new start.
REQ-028 SHALL give rst priority over start in the same cycle.

Configuration
REQ-029 SHALL, with MESH_WALKER_CULL_EN defined, skip (not load, not wait for tri_ready for) any triangle whose three y values are equal, proceeding directly to the next state.
REQ-030 SHALL, without MESH_WALKER_CULL_EN, load every triangle regardless of geometry.

Verification
REQ-031 SHALL test hlast=1, vlast=1, tri_ready=1 always, vertex (r,c) x=10c, y=10r -> exactly 2 loads: T1 (0,0),(10,0),(0,10); T2 (10,0),(10,10),(0,10); then one done pulse.
REQ-032 SHALL test hlast=3, vlast=2 -> 12 loads; vaddr order for cell 1 = 0x001, 0x002, 0x041, 0x042.
REQ-033 SHALL test tri_ready held 0 for 20 cycles after the first load -> no second load until tri_ready returns to 1; outputs stay stable.
REQ-034 SHALL test hlast=0, vlast=5 -> zero loads, done one cycle after start.
REQ-035 SHALL test rst pulsed during WAIT2 of cell 0 -> load=0 and busy=0 next cycle; a subsequent start restarts at cell (0,0).
REQ-036 SHALL test flat row (all y=0 in row 0 and 1 equal) with MESH_WALKER_CULL_EN -> those triangles are not loaded; without the macro -> they are loaded.
